// File: rtl/riscv_branch_pkg.sv
// Shared types and constants for the branch resolution pipeline.
//   - funct3 encodings for conditional branches
//   - control-flow class of a decoded instruction
//   - stage-slot payload carried S1 -> S2 -> S3
//   - small PC helper
package riscv_branch_pkg;

  // Width of the PC/immediate fields held in a stage slot.
  localparam int unsigned SLOT_XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_BR   = 2'd1,
    CLS_JAL  = 2'd2,
    CLS_JALR = 2'd3
  } br_class_e;

  // One pipeline slot; class/funct3/imm are only populated from S3 on.
  typedef struct packed {
    logic                 valid;
    logic [SLOT_XLEN-1:0] pc;
    logic                 pred_taken;
    logic [SLOT_XLEN-1:0] pred_target;
    br_class_e            cls;
    logic [2:0]           funct3;
    logic [SLOT_XLEN-1:0] imm;
  } stage_slot_t;

  // Sequential fall-through address.
  function automatic logic [SLOT_XLEN-1:0] pc_plus4(input logic [SLOT_XLEN-1:0] pc);
    pc_plus4 = pc + SLOT_XLEN'(4);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Conditional-branch comparator.
// Ports:
//   funct3  in  3     branch condition
//   rs1     in  XLEN  first operand
//   rs2     in  XLEN  second operand
//   taken   out 1     condition holds (reserved encodings read not-taken)
module branch_cmp
  import riscv_branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  // Shared compare results.
  always_comb begin
    eq   = (rs1 == rs2);
    lt_s = ($signed(rs1) < $signed(rs2));
    lt_u = (rs1 < rs2);
  end

  // Condition select.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolution pipeline paired with the BTB.
// Carries each fetched PC and its BTB prediction through decode, resolves
// the real outcome at stage 3 and drives the BTB update interface.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   memory_stall        freeze all stage registers and counters
//   flush               stage-3 mispredict from BTB; squash S2/S3
//   pc_1, pred_*_1      fetch PC and BTB prediction
//   is_*_2, funct3_2,   decoder class and fields for the S2 entry
//   imm_2
//   rs1_3, rs2_3        forwarded operands for the S3 entry
//   *_3                 stage-3 resolution outputs (combinational)
//   branch_cnt,         branch and mispredict statistics (wrapping)
//   mispredict_cnt
module branch_resolver
  import riscv_branch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memory_stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  pc_1,
  input  logic             pred_taken_1,
  input  logic [XLEN-1:0]  pred_target_1,
  input  logic             is_branch_2,
  input  logic             is_jal_2,
  input  logic             is_jalr_2,
  input  logic [2:0]       funct3_2,
  input  logic [XLEN-1:0]  imm_2,
  input  logic [XLEN-1:0]  rs1_3,
  input  logic [XLEN-1:0]  rs2_3,
  output logic [XLEN-1:0]  instructionPC_3,
  output logic             is_branchInst_3,
  output logic             taken_3,
  output logic             prev_taken_3,
  output logic [XLEN-1:0]  target_3,
  output logic [XLEN-1:0]  link_pc_3,
  output logic             mispredict_3,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  // Slot PC/imm fields are SLOT_XLEN wide; XLEN is expected to match it.

  stage_slot_t s1_q, s2_q, s3_q;
  stage_slot_t s1_d, s2_d, s3_d;

  logic            advance;
  logic            cmp_taken;
  logic [XLEN-1:0] pc_rel_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] res_target;
  logic            s3_is_cf;

  assign advance = !memory_stall;

  // Next contents of each slot. A flush squashes the two entries younger
  // than the mispredicted branch; the redirected fetch enters S1 as normal.
  always_comb begin
    s1_d             = '0;
    s1_d.valid       = 1'b1;
    s1_d.pc          = pc_1;
    s1_d.pred_taken  = pred_taken_1;
    s1_d.pred_target = pred_target_1;

    s2_d       = s1_q;
    s2_d.valid = s1_q.valid & !flush;

    s3_d        = s2_q;
    s3_d.valid  = s2_q.valid & !flush;
    s3_d.funct3 = funct3_2;
    s3_d.imm    = imm_2;
    if (is_jalr_2) begin
      s3_d.cls = CLS_JALR;
    end else if (is_jal_2) begin
      s3_d.cls = CLS_JAL;
    end else if (is_branch_2) begin
      s3_d.cls = CLS_BR;
    end else begin
      s3_d.cls = CLS_NONE;
    end
  end

  // Stage registers; reset wins over stall and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (advance) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .funct3 (s3_q.funct3),
    .rs1    (rs1_3),
    .rs2    (rs2_3),
    .taken  (cmp_taken)
  );

  // Candidate targets for the S3 entry.
  always_comb begin
    pc_rel_target = s3_q.pc + s3_q.imm;
    jalr_sum      = rs1_3 + s3_q.imm;
    jalr_target   = {jalr_sum[XLEN-1:1], 1'b0};
    res_target    = (s3_q.cls == CLS_JALR) ? jalr_target : pc_rel_target;
  end

  // Stage-3 resolution.
  always_comb begin
    s3_is_cf        = s3_q.valid & (s3_q.cls != CLS_NONE);
    instructionPC_3 = s3_q.pc;
    link_pc_3       = pc_plus4(s3_q.pc);
    prev_taken_3    = s3_q.pred_taken;
    is_branchInst_3 = s3_is_cf;
    taken_3         = 1'b0;
    if (s3_is_cf) begin
      case (s3_q.cls)
        CLS_BR:   taken_3 = cmp_taken;
        CLS_JAL:  taken_3 = 1'b1;
        CLS_JALR: taken_3 = 1'b1;
        default:  taken_3 = 1'b0;
      endcase
    end
    target_3     = taken_3 ? res_target : link_pc_3;
    // A taken prediction must also have named the right target.
    mispredict_3 = s3_is_cf &
                   ((taken_3 != s3_q.pred_taken) |
                    (s3_q.pred_taken & (s3_q.pred_target != res_target)));
  end

  // Statistics, frozen during stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (advance && is_branchInst_3) begin
      branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict_3) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             memory_stall;
  logic             flush;
  logic [XLEN-1:0]  pc_1;
  logic             pred_taken_1;
  logic [XLEN-1:0]  pred_target_1;
  logic             is_branch_2;
  logic             is_jal_2;
  logic             is_jalr_2;
  logic [2:0]       funct3_2;
  logic [XLEN-1:0]  imm_2;
  logic [XLEN-1:0]  rs1_3;
  logic [XLEN-1:0]  rs2_3;
  logic [XLEN-1:0]  instructionPC_3;
  logic             is_branchInst_3;
  logic             taken_3;
  logic             prev_taken_3;
  logic [XLEN-1:0]  target_3;
  logic [XLEN-1:0]  link_pc_3;
  logic             mispredict_3;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  int total;
  int bad;

  branch_resolver #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .memory_stall    (memory_stall),
    .flush           (flush),
    .pc_1            (pc_1),
    .pred_taken_1    (pred_taken_1),
    .pred_target_1   (pred_target_1),
    .is_branch_2     (is_branch_2),
    .is_jal_2        (is_jal_2),
    .is_jalr_2       (is_jalr_2),
    .funct3_2        (funct3_2),
    .imm_2           (imm_2),
    .rs1_3           (rs1_3),
    .rs2_3           (rs2_3),
    .instructionPC_3 (instructionPC_3),
    .is_branchInst_3 (is_branchInst_3),
    .taken_3         (taken_3),
    .prev_taken_3    (prev_taken_3),
    .target_3        (target_3),
    .link_pc_3       (link_pc_3),
    .mispredict_3    (mispredict_3),
    .branch_cnt      (branch_cnt),
    .mispredict_cnt  (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_decode(input logic [1:0] cls, input logic [2:0] f3, input logic [31:0] imm);
    is_branch_2 = (cls == 2'd1);
    is_jal_2    = (cls == 2'd2);
    is_jalr_2   = (cls == 2'd3);
    funct3_2    = f3;
    imm_2       = imm;
  endtask

  // Feeds one instruction (cls: 0 none, 1 branch, 2 JAL, 3 JALR) and returns
  // with it sitting in S3, operands applied and outputs settled.
  task automatic run_instr(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                           input logic [1:0] cls, input logic [2:0] f3,
                           input logic [31:0] imm, input logic [31:0] r1,
                           input logic [31:0] r2);
    pc_1 = pc; pred_taken_1 = pt; pred_target_1 = ptgt;
    step();
    pc_1 = 32'h0; pred_taken_1 = 1'b0; pred_target_1 = 32'h0;
    step();
    set_decode(cls, f3, imm);
    step();
    set_decode(2'd0, 3'd0, 32'h0);
    rs1_3 = r1; rs2_3 = r2;
    #1;
  endtask

  task automatic chk_res(input string tag, input logic br, input logic tk, input logic mis,
                         input logic [31:0] tgt);
    chk({tag, ".is_br"}, 32'(is_branchInst_3), 32'(br));
    chk({tag, ".taken"}, 32'(taken_3), 32'(tk));
    chk({tag, ".mis"}, 32'(mispredict_3), 32'(mis));
    chk({tag, ".target"}, target_3, tgt);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] b, input logic [31:0] m);
    chk({tag, ".branch_cnt"}, branch_cnt, b);
    chk({tag, ".mis_cnt"}, mispredict_cnt, m);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"}, instructionPC_3, 32'h0);
    chk({tag, ".prev"}, 32'(prev_taken_3), 32'h0);
    chk({tag, ".link"}, link_pc_3, 32'h4);
    chk_res(tag, 1'b0, 1'b0, 1'b0, 32'h4);
    chk_cnt(tag, 32'h0, 32'h0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; memory_stall = 1'b0; flush = 1'b0;
    pc_1 = '0; pred_taken_1 = 1'b0; pred_target_1 = '0;
    set_decode(2'd0, 3'd0, 32'h0);
    rs1_3 = '0; rs2_3 = '0;
    step(); step();
    chk_reset("reset");
    rst_n = 1'b1;

    // BEQ equal operands, predicted not-taken.
    run_instr(32'h100, 1'b0, 32'h0, 2'd1, 3'b000, 32'h40, 32'd5, 32'd5);
    chk_res("beq", 1'b1, 1'b1, 1'b1, 32'h140);
    chk("beq.pc", instructionPC_3, 32'h100);
    step();
    chk_cnt("beq", 32'd1, 32'd1);
    chk("bubble.is_br", 32'(is_branchInst_3), 32'h0);

    // BLTU: 0xFFFFFFFF is not below 1 unsigned.
    run_instr(32'h200, 1'b0, 32'h0, 2'd1, 3'b110, 32'h40, 32'hFFFF_FFFF, 32'd1);
    chk_res("bltu", 1'b1, 1'b0, 1'b0, 32'h204);
    step();
    chk_cnt("bltu", 32'd2, 32'd1);

    // BLT: -1 < 1 signed.
    run_instr(32'h300, 1'b0, 32'h0, 2'd1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'd1);
    chk_res("blt", 1'b1, 1'b1, 1'b1, 32'h310);
    step();
    chk_cnt("blt", 32'd3, 32'd2);

    // JALR clears bit 0; correct predicted target.
    run_instr(32'h400, 1'b1, 32'h202, 2'd3, 3'b000, 32'h0, 32'h203, 32'h0);
    chk_res("jalr_ok", 1'b1, 1'b1, 1'b0, 32'h202);
    chk("jalr_ok.link", link_pc_3, 32'h404);
    chk("jalr_ok.prev", 32'(prev_taken_3), 32'h1);
    step();
    chk_cnt("jalr_ok", 32'd4, 32'd2);

    // JALR predicted taken to the wrong target.
    run_instr(32'h400, 1'b1, 32'h300, 2'd3, 3'b000, 32'h0, 32'h203, 32'h0);
    chk_res("jalr_bad", 1'b1, 1'b1, 1'b1, 32'h202);
    step();
    chk_cnt("jalr_bad", 32'd5, 32'd3);

    // JAL backward, and JAL whose target wraps past 2^32.
    run_instr(32'h500, 1'b1, 32'h4F0, 2'd2, 3'b000, 32'hFFFF_FFF0, 32'h0, 32'h0);
    chk_res("jal_back", 1'b1, 1'b1, 1'b0, 32'h4F0);
    run_instr(32'hFFFF_FFF0, 1'b1, 32'h10, 2'd2, 3'b000, 32'h20, 32'h0, 32'h0);
    chk_res("jal_wrap", 1'b1, 1'b1, 1'b0, 32'h10);
    chk("jal_wrap.link", link_pc_3, 32'hFFFF_FFF4);
    step();
    chk_cnt("jal", 32'd7, 32'd3);

    // Flush with branches in S3 (X), S2 (Y) and S1 (Z).
    pc_1 = 32'h600; step();                       // X -> S1
    pc_1 = 32'h700; step();                       // X S2, Y S1
    set_decode(2'd1, 3'b000, 32'h20);
    pc_1 = 32'h800; step();                       // X S3, Y S2, Z S1
    rs1_3 = 32'd9; rs2_3 = 32'd9;
    pc_1 = 32'h900; flush = 1'b1; #1;
    chk_res("flush_x", 1'b1, 1'b1, 1'b1, 32'h620);
    step();
    flush = 1'b0;
    chk("flush.next.is_br", 32'(is_branchInst_3), 32'h0);
    chk("flush.next.mis", 32'(mispredict_3), 32'h0);
    chk_cnt("flush.next", 32'd8, 32'd4);
    step();
    set_decode(2'd0, 3'd0, 32'h0);
    chk("flush.after.is_br", 32'(is_branchInst_3), 32'h0);
    step();
    chk_cnt("flush.after", 32'd8, 32'd4);
    chk("redirect.pc", instructionPC_3, 32'h900);

    // BNE held in S3 across a 3-cycle stall.
    run_instr(32'hA00, 1'b1, 32'hA08, 2'd1, 3'b001, 32'h8, 32'd1, 32'd2);
    chk_res("bne", 1'b1, 1'b1, 1'b0, 32'hA08);
    memory_stall = 1'b1;
    pc_1 = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_res("stall", 1'b1, 1'b1, 1'b0, 32'hA08);
      chk("stall.pc", instructionPC_3, 32'hA00);
      chk_cnt("stall", 32'd8, 32'd4);
    end
    memory_stall = 1'b0;
    step();
    chk_cnt("stall.release", 32'd9, 32'd4);
    step();
    chk_cnt("stall.once", 32'd9, 32'd4);

    // Reset mid-stream with a branch in S3, then reserved funct3.
    run_instr(32'hC00, 1'b0, 32'h0, 2'd1, 3'b000, 32'h40, 32'd3, 32'd3);
    chk("pre_reset.is_br", 32'(is_branchInst_3), 32'h1);
    rst_n = 1'b0;
    step();
    chk_reset("mid_reset");
    rst_n = 1'b1;
    run_instr(32'hD00, 1'b0, 32'h0, 2'd1, 3'b010, 32'h40, 32'd7, 32'd7);
    chk_res("f3_010", 1'b1, 1'b0, 1'b0, 32'hD04);
    step();
    chk_cnt("f3_010", 32'd1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
